// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port word memory between the instruction-fetch port
// (port 0, read-only) and the data load/store port (port 1, read/write).
// Each port uses a level REQ held until a one-cycle ACK pulse. The block turns
// a granted request into registered READ/WRITE/ADDR/DATA memory cycles:
//   read : IDLE -> ACCESS -> RESP -> (ACK cycle, back in IDLE)  3 cycles
//   write: IDLE -> ACCESS -> (ACK cycle, back in IDLE)          2 cycles
// MEM_READ and MEM_WRITE are never asserted together.
//
// Ports
//   CLK, RST        clock (posedge) and asynchronous active-low reset
//   P0_REQ/ADDR     fetch request and word address
//   P0_RDATA/ACK    fetch read data (valid with ACK) and completion pulse
//   P1_REQ/WE/ADDR  data request, write enable, word address
//   P1_WDATA        store data
//   P1_RDATA/ACK    load data (valid with ACK after a read), completion pulse
//   MEM_READ/WRITE  registered memory strobes
//   MEM_ADDR        registered memory word address
//   MEM_DATA_IN     registered write data toward memory
//   MEM_DATA_OUT    read data from memory (valid the cycle after the address)
//   BUSY            high whenever the sequencer is not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 26,
  parameter int DATA_WIDTH     = 32,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  P0_REQ,
  input  logic [ADDR_WIDTH-1:0] P0_ADDR,
  output logic [DATA_WIDTH-1:0] P0_RDATA,
  output logic                  P0_ACK,
  input  logic                  P1_REQ,
  input  logic                  P1_WE,
  input  logic [ADDR_WIDTH-1:0] P1_ADDR,
  input  logic [DATA_WIDTH-1:0] P1_WDATA,
  output logic [DATA_WIDTH-1:0] P1_RDATA,
  output logic                  P1_ACK,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_DATA_IN,
  input  logic [DATA_WIDTH-1:0] MEM_DATA_OUT,
  output logic                  BUSY
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]            state_q,     state_d;
  logic                  last_q,      last_d;      // port granted most recently
  logic                  port_q,      port_d;      // port owning the access
  logic                  mem_read_q,  mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q,  mem_data_d;
  logic [DATA_WIDTH-1:0] p0_rdata_q,  p0_rdata_d;
  logic [DATA_WIDTH-1:0] p1_rdata_q,  p1_rdata_d;
  logic                  p0_ack_q,    p0_ack_d;
  logic                  p1_ack_q,    p1_ack_d;

  logic any_req;
  logic grant_p1;

  // Port 1 wins when it is the only requester, or on a tie in round-robin
  // mode when port 0 took the previous grant.
  assign any_req  = P0_REQ | P1_REQ;
  assign grant_p1 = P1_REQ & (~P0_REQ | (~FIXED_PRIORITY & ~last_q));

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    last_d      = last_q;
    port_d      = port_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          // The latched address/data become the memory outputs directly, so
          // later changes on the request ports cannot reach this access.
          port_d      = grant_p1;
          last_d      = grant_p1;
          mem_addr_d  = grant_p1 ? P1_ADDR : P0_ADDR;
          if (grant_p1) begin
            mem_data_d = P1_WDATA;
          end
          mem_write_d = grant_p1 & P1_WE;
          mem_read_d  = ~(grant_p1 & P1_WE);
          state_d     = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (mem_write_q) begin
          // Memory samples the write at the edge that leaves ACCESS.
          mem_write_d = 1'b0;
          p0_ack_d    = ~port_q;
          p1_ack_d    = port_q;
          state_d     = ST_IDLE;
        end else begin
          // READ stays high through RESP so memory keeps driving the word.
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        mem_read_d = 1'b0;
        if (port_q) begin
          p1_rdata_d = MEM_DATA_OUT;
        end else begin
          p0_rdata_d = MEM_DATA_OUT;
        end
        p0_ack_d = ~port_q;
        p1_ack_d = port_q;
        state_d  = ST_IDLE;
      end

      default: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      port_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      port_q      <= port_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
    end
  end

  assign P0_RDATA    = p0_rdata_q;
  assign P0_ACK      = p0_ack_q;
  assign P1_RDATA    = p1_rdata_q;
  assign P1_ACK      = p1_ack_q;
  assign MEM_READ    = mem_read_q;
  assign MEM_WRITE   = mem_write_q;
  assign MEM_ADDR    = mem_addr_q;
  assign MEM_DATA_IN = mem_data_q;
  assign BUSY        = (state_q != ST_IDLE);

endmodule
